// File: rtl/rv32i_load_store_unit_if.sv
// Core-request, response and data-RAM signal bundle for the RV32I load/store unit.
// slave = LSU side, master = core + RAM side.
interface rv32i_load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ena;
  logic [31:0] mem_rd_data;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rd_data,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wr_data, mem_wr_ena
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rd_data,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wr_data, mem_wr_ena
  );
endinterface

// File: rtl/rv32i_load_store_unit.sv
// RV32I load/store unit for a word-wide synchronous RAM without byte enables; sub-word stores are RMW.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of forcing alignment.
module rv32i_load_store_unit #(
  parameter logic [31:0] MEM_BASE = 32'h0000_0000,
  parameter logic [31:0] MEM_SIZE = 32'h0000_1000
) (
  input  logic                    clk,
  input  logic                    rst,
  rv32i_load_store_unit_if.slave  bus
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, RESP} state_t;

  state_t      state, state_nxt;
  logic        op_write;
  logic [2:0]  op_funct3;
  logic [31:0] op_addr;
  logic [15:0] op_wdata;
  logic [31:0] wbuf;
  logic [31:0] rdata;
  logic        err;
  logic        accept, req_err, req_is_sw;
  logic [31:0] req_addr_eff;
  logic        ready, resp_valid, wr_ena;
  logic [31:0] mem_addr;

  function automatic logic funct3_bad(input logic wr, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return wr;
      default:          return 1'b1;
    endcase
  endfunction

  // Offset compare handles addresses below MEM_BASE through unsigned wrap.
  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - MEM_BASE;
    return off < MEM_SIZE;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
    return (f3[1:0] == 2'b01 && lane[0]) || (f3[1:0] == 2'b10 && lane != 2'b00);
  endfunction
`else
  function automatic logic [31:0] align(input logic [2:0] f3, input logic [31:0] a);
    case (f3[1:0])
      2'b01:   return {a[31:1], 1'b0};
      2'b10:   return {a[31:2], 2'b00};
      default: return a;
    endcase
  endfunction
`endif

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] bs, hs;
    b  = word[{lane, 3'b000} +: 8];
    h  = lane[1] ? word[31:16] : word[15:0];
    bs = b;
    hs = h;
    case (f3)
      F3_B:    return bs;
      F3_H:    return hs;
      F3_BU:   return {24'h0, b};
      F3_HU:   return {16'h0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] word, input logic [15:0] data);
    logic [31:0] r;
    r = word;
    if (f3 == F3_B) r[{lane, 3'b000} +: 8] = data[7:0];
    else            r[{lane[1], 4'b0000} +: 16] = data;
    return r;
  endfunction

  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    req_err      = funct3_bad(bus.req_write, bus.req_funct3) || !in_range(bus.req_addr) ||
                   misaligned(bus.req_funct3, bus.req_addr[1:0]);
    req_addr_eff = bus.req_addr;
`else
    req_err      = funct3_bad(bus.req_write, bus.req_funct3) || !in_range(bus.req_addr);
    req_addr_eff = align(bus.req_funct3, bus.req_addr);
`endif
    req_is_sw    = bus.req_write && (bus.req_funct3 == F3_W);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    resp_valid = 1'b0;
    wr_ena     = 1'b0;
    mem_addr   = 32'h0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.req_valid) begin
          if (req_err)        state_nxt = RESP;
          else if (req_is_sw) state_nxt = WRITE;
          else                state_nxt = READ;
        end
      end
      READ: begin
        mem_addr  = {op_addr[31:2], 2'b00};
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        mem_addr  = {op_addr[31:2], 2'b00};
        state_nxt = op_write ? WRITE : RESP;
      end
      WRITE: begin
        mem_addr  = {op_addr[31:2], 2'b00};
        wr_ena    = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset gates the bus immediately so an in-flight RMW write is never issued.
    if (rst) begin
      ready      = 1'b0;
      resp_valid = 1'b0;
      wr_ena     = 1'b0;
      mem_addr   = 32'h0;
    end
  end

  assign accept = bus.req_valid && ready;

  // Request latch: operands held for the whole access.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_write  <= bus.req_write;
      op_funct3 <= bus.req_funct3;
      op_addr   <= req_addr_eff;
      op_wdata  <= bus.req_wdata[15:0];
    end
  end

  // Response and write-buffer registers update only on the edge entering RESP or WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbuf  <= 32'h0;
      rdata <= 32'h0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (req_err) begin
              rdata <= 32'h0;
              err   <= 1'b1;
            end else if (req_is_sw) begin
              wbuf <= bus.req_wdata;
            end
          end
        end
        CAPTURE: begin
          if (op_write) begin
            wbuf <= store_merge(op_funct3, op_addr[1:0], bus.mem_rd_data, op_wdata);
          end else begin
            rdata <= load_extract(op_funct3, op_addr[1:0], bus.mem_rd_data);
            err   <= 1'b0;
          end
        end
        WRITE: begin
          rdata <= 32'h0;
          err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = ready;
  assign bus.resp_valid  = resp_valid;
  assign bus.resp_rdata  = rdata;
  assign bus.resp_err    = err;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wr_data = wbuf;
  assign bus.mem_wr_ena  = wr_ena;

endmodule
